nbdcache_tag_arbiter: RTL and testbench
=======================================

// Module: nbdcache_tag_arbiter
// PURPOSE
// Parametrised memory-arbitration and tag-compare stage for the next-generation non-blocking dcache.
// Sits between NR_PORTS cache controllers/miss handler and the SET_ASSOC data/tag/valid-dirty SRAM banks.
// Generalises the 4-port fixed-priority stage with:
//   - configurable port count and associativity
//   - a round-robin mode
//   - port lock for multi-cycle sequences
//   - per-port read-valid strobes and a multi-hit error flag
// PARAMETERS
// NR_PORTS     4    requesting ports; port 0 = miss handler
// SET_ASSOC    8    ways
// INDEX_WIDTH  12   set index + byte offset bits
// TAG_WIDTH    44   tag bits
// DATA_WIDTH   128  line data bits
// ARB_MODE     0    0: fixed priority, lowest index wins; 1: round-robin
// LINE_W (local) = DATA_WIDTH+TAG_WIDTH+2, packed {valid,dirty,tag,data}
// BE_W (local)   = DATA_WIDTH/8 + (TAG_WIDTH+7)/8 + SET_ASSOC, packed {vldrty,tag,data}
// PORTS
// clk_i       in   1                      clock
// rst_i       in   1                      synchronous reset, active-high
// req_i       in   NR_PORTS*SET_ASSOC     per-port way select; any bit set = request
// addr_i      in   NR_PORTS*INDEX_WIDTH   per-port index
// tag_i       in   NR_PORTS*TAG_WIDTH     per-port compare tag, valid the cycle after grant
// wdata_i     in   NR_PORTS*LINE_W        per-port write line
// we_i        in   NR_PORTS               per-port write enable
// be_i        in   NR_PORTS*BE_W          per-port byte enables
// lock_i      in   NR_PORTS               hold arbitration ownership
// gnt_o       out  NR_PORTS               one-hot grant, same cycle as request
// rvalid_o    out  NR_PORTS               read result valid for port (cycle after grant)
// rdata_o     out  SET_ASSOC*LINE_W       all-way read data
// hit_way_o   out  SET_ASSOC              tag-match vector
// multi_hit_o out  1                      >1 way hit (error pulse)
// ram_req_o   out  SET_ASSOC              to SRAM banks
// ram_addr_o  out  INDEX_WIDTH
// ram_we_o    out  1
// ram_wdata_o out  LINE_W
// ram_be_o    out  BE_W
// ram_rdata_i in   SET_ASSOC*LINE_W       SRAM read data, 1-cycle latency
// BEHAVIOUR
// - Arbitration (comb, cycle 0):
//   - Requesting = |req_i[p].
//   - Fixed: lowest requesting index wins.
//   - RR: first requesting port at or after rr_q, wrapping NR_PORTS-1 -> 0.
//   - Winner's req/addr/we/wdata/be drive ram_*.
//   - No winner: ram_req_o=0, ram_we_o=0, ram_addr_o=0.
// - rr_q: on any grant, <= (winner+1) mod NR_PORTS. Width max(1,$clog2(NR_PORTS)).
// - Lock:
//   - Granted port with lock_i=1 sets lock_q=1, owner_q=winner.
//   - While lock_q, only owner_q can be granted; others see gnt=0 even if owner idle.
//   - Owner dropping lock_i clears lock_q at the next edge.
//   - lock_i from a non-owner is ignored.
// - Response (cycle 1):
//   - sel_q <= winner; rd_q <= grant & ~we.
//   - rdata_o = ram_rdata_i (pass-through).
//   - hit_way_o[w] = rd_q & valid[w] & (tag[w]==tag_i[sel_q]).
//   - rvalid_o[sel_q] = rd_q; all other bits 0.
//   - multi_hit_o = rd_q & ($countones(hit_way_o)>1).
// - Writes: same-cycle to SRAM; no rvalid, no hit.
// - Back-to-back: a new grant every cycle; no bubbles. The response for grant N coincides with arbitration of N+1.
// - Reset (rst_i=1): gnt_o=0, ram_req_o=0, ram_we_o=0, rvalid_o=0, hit_way_o=0, multi_hit_o=0.
//   Next edge: rr_q=0, lock_q=0, owner_q=0, sel_q=0, rd_q=0.
//   A read granted the cycle before reset gives no rvalid.
// - NR_PORTS=1: always port 0; lock is a no-op.
// STRUCTURE
// - std_cache_pkg: arb_mode_e {ARB_FIXED, ARB_RR}.
//   Line/BE packing is local (parameter dependent).
// - Sub-module: dcache_lock_rr_arb (NR_PORTS, ARB_MODE). Contains request vector, lock, gnt, winner index, rr_q/lock_q/owner_q.
// - Top: muxing, response regs, tag compare, multi-hit.
// TESTING
// - Reset: rst_i=1 with all req_i set -> gnt_o=0, ram_req_o=0. After release, RR first grant = port 0.
// - Fixed mode: ports 1,3 request continuously -> port 1 granted every cycle, port 3 starved.
// - RR mode: ports 0,2,3 request continuously -> grants 0,2,3,0,2 (wrap); rr_q returns to 1 after port 0.
// - Lock: port 2 grant with lock_i[2]=1 for 3 cycles, port 0 requesting -> port 0 gnt=0 while locked; granted the cycle after lock_i[2] drops.
// - Hit: way 5 valid, tag 0xABC; port 1 reads, tag_i[1]=0xABC next cycle -> hit_way_o=8'b0010_0000, rvalid_o=4'b0010. Mismatch tag -> hit_way_o=0.
// - Multi-hit and write: ways 1,4 hold the same tag -> multi_hit_o=1 for one cycle. A write grant gives rvalid_o=0 the next cycle.

Source files
------------

// File: rtl/std_cache_pkg.sv
// Shared definitions for the non-blocking dcache arbitration stage.
package std_cache_pkg;

    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/dcache_lock_rr_arb.sv
// Port arbiter for the dcache SRAM stage: fixed-priority or round-robin,
// with a lock that keeps ownership on one port across multi-cycle sequences.
module dcache_lock_rr_arb
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS = 4,
    parameter arb_mode_e   ARB_MODE = ARB_FIXED,
    localparam int unsigned IDX_W   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NR_PORTS-1:0] req,
    input  logic [NR_PORTS-1:0] lock,
    output logic [NR_PORTS-1:0] gnt,
    output logic                granted,
    output logic [IDX_W-1:0]    winner
);

    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] owner_q;
    logic             lock_q;

    // base < NR_PORTS and off < NR_PORTS, so one conditional subtract wraps
    function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= NR_PORTS) s = s - NR_PORTS;
        return IDX_W'(s);
    endfunction

    always_comb begin
        winner  = '0;
        granted = 1'b0;
        if (lock_q) begin
            winner  = owner_q;
            granted = req[owner_q];
        end else if (ARB_MODE == ARB_RR) begin
            for (int unsigned i = 0; i < NR_PORTS; i++) begin
                if (!granted && req[wrap_idx(32'(rr_q), i)]) begin
                    granted = 1'b1;
                    winner  = wrap_idx(32'(rr_q), i);
                end
            end
        end else begin
            for (int unsigned i = 0; i < NR_PORTS; i++) begin
                if (!granted && req[i]) begin
                    granted = 1'b1;
                    winner  = IDX_W'(i);
                end
            end
        end
        if (rst) granted = 1'b0;
    end

    always_comb begin
        gnt = '0;
        if (granted) gnt[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else begin
            if (granted) rr_q <= wrap_idx(32'(winner), 1);
            // Lock only releases on the owner's own lock_i; a single port never locks
            if (lock_q) begin
                lock_q <= lock[owner_q];
            end else if (granted && lock[winner] && (NR_PORTS > 1)) begin
                lock_q  <= 1'b1;
                owner_q <= winner;
            end
        end
    end

endmodule

// File: rtl/nbdcache_tag_arbiter.sv
// Dcache SRAM arbitration and tag-compare stage: muxes the winning port onto
// the SRAM banks and compares all ways against that port's tag one cycle later.
module nbdcache_tag_arbiter
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS    = 4,
    parameter int unsigned SET_ASSOC   = 8,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned TAG_WIDTH   = 44,
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned ARB_MODE    = 0,
    localparam int unsigned LINE_W     = DATA_WIDTH + TAG_WIDTH + 2,
    localparam int unsigned BE_W       = DATA_WIDTH/8 + (TAG_WIDTH+7)/8 + SET_ASSOC
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NR_PORTS*SET_ASSOC-1:0]   req_i,
    input  logic [NR_PORTS*INDEX_WIDTH-1:0] addr_i,
    input  logic [NR_PORTS*TAG_WIDTH-1:0]   tag_i,
    input  logic [NR_PORTS*LINE_W-1:0]      wdata_i,
    input  logic [NR_PORTS-1:0]             we_i,
    input  logic [NR_PORTS*BE_W-1:0]        be_i,
    input  logic [NR_PORTS-1:0]             lock_i,
    output logic [NR_PORTS-1:0]             gnt_o,
    output logic [NR_PORTS-1:0]             rvalid_o,
    output logic [SET_ASSOC*LINE_W-1:0]     rdata_o,
    output logic [SET_ASSOC-1:0]            hit_way_o,
    output logic                            multi_hit_o,
    output logic [SET_ASSOC-1:0]            ram_req_o,
    output logic [INDEX_WIDTH-1:0]          ram_addr_o,
    output logic                            ram_we_o,
    output logic [LINE_W-1:0]               ram_wdata_o,
    output logic [BE_W-1:0]                 ram_be_o,
    input  logic [SET_ASSOC*LINE_W-1:0]     ram_rdata_i
);

    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [NR_PORTS-1:0]  port_req;
    logic                 granted;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     sel_q;
    logic                 rd_q;
    logic                 rd;
    logic [TAG_WIDTH-1:0] cmp_tag;

    always_comb begin
        port_req = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            port_req[p] = |req_i[p*SET_ASSOC +: SET_ASSOC];
        end
    end

    dcache_lock_rr_arb #(
        .NR_PORTS (NR_PORTS),
        .ARB_MODE ((ARB_MODE != 0) ? ARB_RR : ARB_FIXED)
    ) u_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     (port_req),
        .lock    (lock_i),
        .gnt     (gnt_o),
        .granted (granted),
        .winner  (winner)
    );

    always_comb begin
        ram_req_o   = '0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_wdata_o = wdata_i[32'(winner)*LINE_W +: LINE_W];
        ram_be_o    = be_i[32'(winner)*BE_W +: BE_W];
        if (granted) begin
            ram_req_o  = req_i[32'(winner)*SET_ASSOC +: SET_ASSOC];
            ram_addr_o = addr_i[32'(winner)*INDEX_WIDTH +: INDEX_WIDTH];
            ram_we_o   = we_i[winner];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q <= '0;
            rd_q  <= 1'b0;
        end else begin
            sel_q <= winner;
            rd_q  <= granted & ~we_i[winner];
        end
    end

    // Gating with rst_i drops the response of a read granted just before reset
    assign rd      = rd_q & ~rst_i;
    assign rdata_o = ram_rdata_i;
    assign cmp_tag = tag_i[32'(sel_q)*TAG_WIDTH +: TAG_WIDTH];

    always_comb begin
        hit_way_o = '0;
        for (int unsigned w = 0; w < SET_ASSOC; w++) begin
            hit_way_o[w] = rd & ram_rdata_i[w*LINE_W + LINE_W - 1]
                         & (ram_rdata_i[w*LINE_W + DATA_WIDTH +: TAG_WIDTH] == cmp_tag);
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            rvalid_o[p] = rd & (sel_q == IDX_W'(p));
        end
    end

    assign multi_hit_o = rd & ($countones(hit_way_o) > 1);

endmodule

// File: tb/tb_nbdcache_tag_arbiter.sv
// Bench for nbdcache_tag_arbiter: fixed and round-robin instances share stimulus
// and are compared against a cycle-level reference model of the arbitration rules.
module tb_nbdcache_tag_arbiter;

    localparam int N  = 4;
    localparam int SA = 8;
    localparam int IW = 12;
    localparam int TW = 44;
    localparam int DW = 128;
    localparam int LW = DW + TW + 2;
    localparam int BW = DW/8 + (TW+7)/8 + SA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N*SA-1:0] req;
    logic [N*IW-1:0] addr;
    logic [N*TW-1:0] tag;
    logic [N*LW-1:0] wdata;
    logic [N-1:0]    we;
    logic [N*BW-1:0] be;
    logic [N-1:0]    lock;
    logic [SA*LW-1:0] rdata;

    logic [N-1:0]     gnt_f, rvalid_f, gnt_r, rvalid_r;
    logic [SA*LW-1:0] rdata_f, rdata_r;
    logic [SA-1:0]    hit_f, hit_r, ram_req_f, ram_req_r;
    logic             multi_f, multi_r, ram_we_f, ram_we_r;
    logic [IW-1:0]    ram_addr_f, ram_addr_r;
    logic [LW-1:0]    ram_wdata_f, ram_wdata_r;
    logic [BW-1:0]    ram_be_f, ram_be_r;

    nbdcache_tag_arbiter #(
        .NR_PORTS(N), .SET_ASSOC(SA), .INDEX_WIDTH(IW), .TAG_WIDTH(TW),
        .DATA_WIDTH(DW), .ARB_MODE(0)
    ) u_fix (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .tag_i(tag),
        .wdata_i(wdata), .we_i(we), .be_i(be), .lock_i(lock),
        .gnt_o(gnt_f), .rvalid_o(rvalid_f), .rdata_o(rdata_f), .hit_way_o(hit_f),
        .multi_hit_o(multi_f), .ram_req_o(ram_req_f), .ram_addr_o(ram_addr_f),
        .ram_we_o(ram_we_f), .ram_wdata_o(ram_wdata_f), .ram_be_o(ram_be_f),
        .ram_rdata_i(rdata)
    );

    nbdcache_tag_arbiter #(
        .NR_PORTS(N), .SET_ASSOC(SA), .INDEX_WIDTH(IW), .TAG_WIDTH(TW),
        .DATA_WIDTH(DW), .ARB_MODE(1)
    ) u_rr (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .tag_i(tag),
        .wdata_i(wdata), .we_i(we), .be_i(be), .lock_i(lock),
        .gnt_o(gnt_r), .rvalid_o(rvalid_r), .rdata_o(rdata_r), .hit_way_o(hit_r),
        .multi_hit_o(multi_r), .ram_req_o(ram_req_r), .ram_addr_o(ram_addr_r),
        .ram_we_o(ram_we_r), .ram_wdata_o(ram_wdata_r), .ram_be_o(ram_be_r),
        .ram_rdata_i(rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state per instance: 0 = fixed, 1 = round-robin
    int rr_m[2];
    int owner_m[2];
    int sel_m[2];
    bit lock_m[2];
    bit rd_m[2];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else n_pass++;
    endtask

    function automatic logic [LW-1:0] mk_line(input bit v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        return {v, 1'b0, t, d};
    endfunction

    function automatic logic [TW-1:0] pick_tag();
        case ($urandom_range(0, 2))
            0:       return TW'(44'hABC);
            1:       return TW'(44'h123);
            default: return TW'(44'h555);
        endcase
    endfunction

    task automatic model_check(input int m,
                               input logic [N-1:0] g, input logic [N-1:0] rv,
                               input logic [SA-1:0] hw, input logic mh,
                               input logic [SA-1:0] rq, input logic [IW-1:0] ra,
                               input logic rwe, input logic [LW-1:0] rwd);
        string nm;
        int win;
        int idx;
        int hits;
        logic [N-1:0] reqv;
        logic [N-1:0] exp_g;
        logic [N-1:0] exp_rv;
        logic [SA-1:0] exp_hw;
        logic [LW-1:0] ln;
        nm = (m == 0) ? "fix" : "rr";
        win = -1;
        for (int p = 0; p < N; p++) reqv[p] = |req[p*SA +: SA];
        if (!rst) begin
            if (lock_m[m]) begin
                if (reqv[owner_m[m]]) win = owner_m[m];
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m == 0) ? k : (rr_m[m] + k) % N;
                    if (win < 0 && reqv[idx]) win = idx;
                end
            end
        end
        exp_g = '0;
        if (win >= 0) exp_g[win] = 1'b1;
        check({nm, "_gnt"}, 256'(g), 256'(exp_g));
        check({nm, "_ram_req"}, 256'(rq), (win >= 0) ? 256'(req[win*SA +: SA]) : 256'(0));
        check({nm, "_ram_addr"}, 256'(ra), (win >= 0) ? 256'(addr[win*IW +: IW]) : 256'(0));
        check({nm, "_ram_we"}, 256'(rwe), (win >= 0) ? 256'(we[win]) : 256'(0));
        if (win >= 0) check({nm, "_ram_wdata"}, 256'(rwd), 256'(wdata[win*LW +: LW]));

        exp_rv = '0;
        exp_hw = '0;
        hits = 0;
        if (!rst && rd_m[m]) begin
            exp_rv[sel_m[m]] = 1'b1;
            for (int w = 0; w < SA; w++) begin
                ln = rdata[w*LW +: LW];
                if (ln[LW-1] && ln[DW +: TW] == tag[sel_m[m]*TW +: TW]) begin
                    exp_hw[w] = 1'b1;
                    hits++;
                end
            end
        end
        check({nm, "_rvalid"}, 256'(rv), 256'(exp_rv));
        check({nm, "_hit_way"}, 256'(hw), 256'(exp_hw));
        check({nm, "_multi_hit"}, 256'(mh), 256'(hits > 1));

        if (rst) begin
            rr_m[m] = 0; lock_m[m] = 0; owner_m[m] = 0; rd_m[m] = 0; sel_m[m] = 0;
        end else begin
            rd_m[m] = (win >= 0) && !we[win];
            if (win >= 0) begin
                sel_m[m] = win;
                rr_m[m]  = (win + 1) % N;
            end
            if (lock_m[m]) lock_m[m] = lock[owner_m[m]];
            else if (win >= 0 && lock[win]) begin
                lock_m[m]  = 1;
                owner_m[m] = win;
            end
        end
    endtask

    task automatic run_cycle();
        #1;
        model_check(0, gnt_f, rvalid_f, hit_f, multi_f, ram_req_f, ram_addr_f, ram_we_f, ram_wdata_f);
        model_check(1, gnt_r, rvalid_r, hit_r, multi_r, ram_req_r, ram_addr_r, ram_we_r, ram_wdata_r);
        @(negedge clk);
    endtask

    task automatic clear_in();
        req = '0; we = '0; lock = '0;
    endtask

    task automatic read_port1();
        clear_in();
        req[1*SA +: SA] = 8'h20;
        run_cycle();
        clear_in();
    endtask

    task automatic set_ways(input logic [SA-1:0] valid, input logic [TW-1:0] t);
        for (int w = 0; w < SA; w++)
            rdata[w*LW +: LW] = mk_line(valid[w], t, {$urandom, $urandom, $urandom, $urandom});
    endtask

    initial begin
        logic [N-1:0] rr_seq [5];
        rr_seq = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
        for (int i = 0; i < 2; i++) begin
            rr_m[i] = 0; owner_m[i] = 0; sel_m[i] = 0; lock_m[i] = 0; rd_m[i] = 0;
        end
        rst = 1'b1; req = '1; we = '0; lock = '0;
        addr = '0; tag = '0; wdata = '0; be = '0; rdata = '0;
        for (int p = 0; p < N; p++) addr[p*IW +: IW] = IW'(p * 16 + 3);
        @(negedge clk);

        // Reset with every port requesting
        #1;
        check("rst_gnt_fix", 256'(gnt_f), 256'(0));
        check("rst_gnt_rr", 256'(gnt_r), 256'(0));
        check("rst_ram_req", 256'(ram_req_r), 256'(0));
        run_cycle();
        run_cycle();
        rst = 1'b0;
        #1 check("rr_first_after_rst", 256'(gnt_r), 256'(4'b0001));
        run_cycle();

        // Fixed priority: port 3 starved by port 1
        clear_in();
        req[1*SA +: SA] = 8'h01;
        req[3*SA +: SA] = 8'h80;
        for (int i = 0; i < 5; i++) begin
            #1 check("fix_starve", 256'(gnt_f), 256'(4'b0010));
            run_cycle();
        end

        // Round-robin wrap over ports 0,2,3
        rst = 1'b1; clear_in(); run_cycle(); rst = 1'b0;
        req[0*SA +: SA] = 8'h01; req[2*SA +: SA] = 8'h02; req[3*SA +: SA] = 8'h04;
        for (int i = 0; i < 5; i++) begin
            #1 check("rr_seq", 256'(gnt_r), 256'(rr_seq[i]));
            run_cycle();
            if (i == 0) check("rr_ptr_after_p0", 256'(u_rr.u_arb.rr_q), 256'(1));
        end

        // Lock held by port 2 while port 0 waits
        clear_in();
        req[2*SA +: SA] = 8'h04; lock[2] = 1'b1;
        #1 check("lock_take", 256'(gnt_f), 256'(4'b0100));
        run_cycle();
        req[0*SA +: SA] = 8'h01;
        for (int i = 0; i < 2; i++) begin
            #1 check("lock_hold_fix", 256'(gnt_f), 256'(4'b0100));
            check("lock_hold_rr", 256'(gnt_r), 256'(4'b0100));
            run_cycle();
        end
        req[2*SA +: SA] = 8'h00;
        #1 check("lock_owner_idle", 256'(gnt_f | gnt_r), 256'(0));
        run_cycle();
        req[2*SA +: SA] = 8'h04; lock[2] = 1'b0;
        #1 check("lock_drop_cycle", 256'(gnt_f), 256'(4'b0100));
        run_cycle();
        #1 check("lock_released_fix", 256'(gnt_f), 256'(4'b0001));
        check("lock_released_rr", 256'(gnt_r), 256'(4'b0001));
        run_cycle();

        // Single hit on way 5, then tag mismatch
        read_port1();
        tag[1*TW +: TW] = TW'(44'hABC);
        set_ways(8'h00, TW'(44'h0));
        rdata[5*LW +: LW] = mk_line(1'b1, TW'(44'hABC), {$urandom, $urandom, $urandom, $urandom});
        #1 check("hit_way5", 256'(hit_f), 256'(8'b0010_0000));
        check("hit_rvalid", 256'(rvalid_f), 256'(4'b0010));
        check("hit_rdata_pass", 256'(rdata_r[5*LW +: LW]), 256'(rdata[5*LW +: LW]));
        run_cycle();
        read_port1();
        tag[1*TW +: TW] = TW'(44'hABD);
        #1 check("miss_hit_way", 256'(hit_r), 256'(0));
        check("miss_rvalid", 256'(rvalid_r), 256'(4'b0010));
        run_cycle();

        // Multi-hit on ways 1 and 4 for a single cycle
        read_port1();
        tag[1*TW +: TW] = TW'(44'hABC);
        set_ways(8'b0001_0010, TW'(44'hABC));
        #1 check("multi_hit", 256'(multi_f), 256'(1));
        check("multi_hit_way", 256'(hit_f), 256'(8'b0001_0010));
        run_cycle();
        #1 check("multi_hit_pulse", 256'(multi_f), 256'(0));
        run_cycle();

        // Write grant produces no read response
        clear_in();
        req[1*SA +: SA] = 8'h20; we[1] = 1'b1;
        #1 check("write_ram_we", 256'(ram_we_f), 256'(1));
        run_cycle();
        clear_in();
        #1 check("write_no_rvalid", 256'(rvalid_f | rvalid_r), 256'(0));
        run_cycle();

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) < 3);
            for (int p = 0; p < N; p++) begin
                req[p*SA +: SA]   = ($urandom_range(0, 1) == 1) ? SA'($urandom_range(1, 255)) : '0;
                we[p]             = ($urandom_range(0, 3) == 0);
                lock[p]           = ($urandom_range(0, 4) == 0);
                addr[p*IW +: IW]  = IW'($urandom);
                tag[p*TW +: TW]   = pick_tag();
                wdata[p*LW +: LW] = LW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
                be[p*BW +: BW]    = BW'($urandom);
            end
            for (int w = 0; w < SA; w++)
                rdata[w*LW +: LW] = mk_line($urandom_range(0, 1) == 1, pick_tag(),
                                            {$urandom, $urandom, $urandom, $urandom});
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
